cla_seq_adder: RTL and testbench

//  Multi-cycle wide adder controller. Drives one shared 8-bit carry-lookahead slice across

---
 rtl/cla_seq_pkg.sv | 21 ++
 rtl/cla_seq_adder_if.sv | 37 +++
 rtl/cla_add8_slice.sv | 38 +++
 rtl/cla_seq_adder.sv | 115 +++++++++++
 tb/tb_cla_seq_adder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the sequential chunked adder: state encoding, chunk width
// and index-width helper.
package cla_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  localparam int unsigned ChunkW = 8;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder. The sub line exists only when
// CLA_SEQ_SUB_EN is defined.
interface cla_seq_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/cla_add8_slice.sv
// Combinational 8-bit carry-lookahead adder: two 4-bit lookahead cells, carry passed
// from the low cell to the high cell.
module cla_add8_slice (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  // Returns {carry_out, sum[3:0]} with all carries computed in parallel from g/p.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic [4:0] lo;
  logic [4:0] hi;

  always_comb begin
    lo     = cla4(a_i[3:0], b_i[3:0], cin_i);
    hi     = cla4(a_i[7:4], b_i[7:4], lo[4]);
    sum_o  = {hi[3:0], lo[3:0]};
    cout_o = hi[4];
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 8-bit CLA slice, LSB chunk first.
// Define CLA_SEQ_SUB_EN to add the sub input (A-B via ~B and carry-in 1).
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  cla_seq_adder_if.slave bus
);

  localparam int unsigned NChunk = WIDTH / ChunkW;
  localparam int unsigned IdxW   = idx_width(NChunk);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

  state_t           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             in_ready;
  logic [7:0]       slice_a;
  logic [7:0]       slice_b;
  logic [7:0]       slice_sum;
  logic             slice_cout;

  assign in_ready = rst_n && (state_q == StIdle);
  assign slice_a  = a_q[ChunkW*idx_q +: ChunkW];
  assign slice_b  = b_q[ChunkW*idx_q +: ChunkW];

  cla_add8_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready) begin
          a_d     = bus.a;
`ifdef CLA_SEQ_SUB_EN
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d[ChunkW*idx_q +: ChunkW] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // Publish the work register including the chunk written this cycle.
          sum_d   = work_d;
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=32): vector table plus handshake/reset sequences.
module tb_cla_seq_adder;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  cla_seq_adder_if #(.WIDTH(32)) bus ();

  cla_seq_adder #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef CLA_SEQ_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: sub vector skipped without CLA_SEQ_SUB_EN");
`endif
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, output logic [31:0] s, output logic c,
                        output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("accept_timeout", 64'(w), 64'd0);
    drive(a, b, cin, sub);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 20);
    s = bus.sum;
    c = bus.cout;
  endtask

  vec_t        vecs[8];
  logic [31:0] s;
  logic        c;
  int          lat;
  int          cnt;

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);

    // Power-on reset.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, c, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd4);
      check($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 64'(c), 64'(vecs[i].cout));
    end

    // Busy duration for one operation with out_ready held high.
    @(negedge clk);
    drive(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    check("busy_cycles", 64'(cnt), 64'd5);
    check("busy_sum_hold", 64'(bus.sum), 64'h2222_2222);

    // Reset mid-traffic for three cycles.
    drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_sum", 64'(bus.sum), 64'd0);
      check("midrst_cout", 64'(bus.cout), 64'd0);
    end
    rst_n = 1'b1;
    #1 check("midrst_rel_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Back-pressure: result held, second op waits for the handshake.
    bus.out_ready = 1'b0;
    run_op(32'h10, 32'h5, 1'b0, 1'b0, s, c, lat);
    check("bp_first_sum", 64'(s), 64'h15);
    drive(32'h1, 32'h1, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_sum_hold", 64'(bus.sum), 64'h15);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 64'(bus.in_ready), 64'd1);
    check("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_sum_after_hs", 64'(bus.sum), 64'h15);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 20);
    check("bp_second_lat", 64'(lat), 64'd4);
    check("bp_second_sum", 64'(bus.sum), 64'h2);

    // One-cycle reset while chunk index is 2.
    @(negedge clk);
    drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("idx2rst_sum", 64'(bus.sum), 64'd0);
    check("idx2rst_busy", 64'(bus.busy), 64'd0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("idx2rst_no_valid", 64'(cnt), 64'd0);
    run_op(32'h10, 32'h20, 1'b0, 1'b0, s, c, lat);
    check("idx2rst_next_sum", 64'(s), 64'h30);
    check("idx2rst_next_cout", 64'(c), 64'd0);

`ifdef CLA_SEQ_SUB_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, s, c, lat);
    check("sub_5m7_sum", 64'(s), 64'hFFFF_FFFE);
    check("sub_5m7_cout", 64'(c), 64'd0);
    run_op(32'd7, 32'd5, 1'b1, 1'b1, s, c, lat);
    check("sub_7m5_sum", 64'(s), 64'h2);
    check("sub_7m5_cout", 64'(c), 64'd1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
